// File: rtl/mem_req_ctrl.sv
// Queued memory request controller: a small request FIFO feeding a single-port memory FSM.
// Optional write-verify read-back is compiled in with `define MEM_REQ_CTRL_VERIFY_EN.
module mem_req_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  verify_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_RWAIT = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
`ifdef MEM_REQ_CTRL_VERIFY_EN
    localparam logic [2:0] S_VRD   = 3'd5;
    localparam logic [2:0] S_VWAIT = 3'd6;
`endif

    logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_wr;
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_req_ready;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_count_nxt;

    // Pop only from IDLE, so the head is never consumed while a request is in flight.
    assign w_push      = req_valid & r_req_ready;
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= req_addr;
            r_fifo_data[r_wptr] <= req_wdata;
            r_fifo_wr[r_wptr]   <= req_write;
        end
    end

    // Ready is registered from the next count, so it rises one edge after reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_req_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            r_count     <= w_count_nxt;
            r_req_ready <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_state_nxt = r_fifo_wr[r_rptr] ? S_WR : S_RD;
`ifdef MEM_REQ_CTRL_VERIFY_EN
            S_WR:    w_state_nxt = S_VRD;
            S_VRD:   w_state_nxt = S_VWAIT;
            S_VWAIT: w_state_nxt = S_IDLE;
`else
            S_WR:    w_state_nxt = S_IDLE;
`endif
            S_RD:    w_state_nxt = S_RWAIT;
            S_RWAIT: w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_addr  <= r_fifo_addr[r_rptr];
                r_wdata <= r_fifo_data[r_rptr];
                r_write <= r_fifo_wr[r_rptr];
            end
            if (r_state == S_RWAIT) r_rdata <= mem_rdata;
        end
    end

`ifdef MEM_REQ_CTRL_VERIFY_EN
    logic r_verify_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_verify_err <= 1'b0;
        end else if ((r_state == S_VWAIT) && (mem_rdata != r_wdata)) begin
            r_verify_err <= 1'b1;
        end
    end

    assign verify_err = r_verify_err;
    assign mem_cs     = (r_state == S_WR) || (r_state == S_RD) || (r_state == S_VRD);
    assign mem_re     = (r_state == S_RD) || (r_state == S_VRD);
`else
    assign verify_err = 1'b0;
    assign mem_cs     = (r_state == S_WR) || (r_state == S_RD);
    assign mem_re     = (r_state == S_RD);
`endif

    assign mem_we    = (r_state == S_WR) && r_write;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign req_ready = r_req_ready;
    assign busy      = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a 1-cycle-latency memory model.
module tb_mem_req_ctrl;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_cs;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          verify_err;

    int compared   = 0;
    int mismatched = 0;

    mem_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    // Memory model: unwritten locations read as 0xA50000<addr[7:0]>.
    logic [DW-1:0] mem [256];
    logic [255:0]  wr_flag = '0;
    logic          zero_rd;

    always @(posedge clk) begin
        if (mem_cs && mem_we) begin
            mem[mem_addr[7:0]]     <= mem_wdata;
            wr_flag[mem_addr[7:0]] <= 1'b1;
        end
        if (mem_cs && mem_re)
            mem_rdata <= zero_rd ? '0 :
                         (wr_flag[mem_addr[7:0]] ? mem[mem_addr[7:0]] : {24'hA50000, mem_addr[7:0]});
    end

    int   we_total = 0, overlap_total = 0, adj_total = 0, rsp_total = 0;
    logic prev_we = 1'b0;

    always begin
        @(negedge clk);
        #1;
        if (mem_we) we_total++;
        if (mem_we && mem_re) overlap_total++;
        if (mem_we && prev_we) adj_total++;
        prev_we = mem_we;
        if (rsp_valid && rsp_ready) rsp_total++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) chk("push_ready_timeout", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [DW-1:0] exp);
        int n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 64'(rsp_valid), 64'(1));
        chk(tag, 64'(rsp_rdata), 64'(exp));
        rsp_ready = 1'b1;
        if (rsp_valid) tick();
    endtask

    initial begin
        int snap;
        logic [DW-1:0] d;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0; zero_rd = 1'b0;

        // Reset state
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_mem_cs", 64'(mem_cs), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_verify_err", 64'(verify_err), 64'(0));
        tick();
        tick();
        reset = 1'b0;
        chk("rdy_before_edge", 64'(req_ready), 64'(0));
        tick();
        chk("rdy_after_edge", 64'(req_ready), 64'(1));

        // Single read at 0x1234: strobe in N+1..N+2, response from N+3
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1234;
        tick();
        req_valid = 1'b0;
        chk("lat_cs_n", 64'(mem_cs), 64'(0));
        chk("lat_busy", 64'(busy), 64'(1));
        tick();
        chk("lat_cs_n1", 64'(mem_cs), 64'(1));
        chk("lat_re_n1", 64'(mem_re), 64'(1));
        chk("lat_we_n1", 64'(mem_we), 64'(0));
        chk("lat_addr_n1", 64'(mem_addr), 64'(16'h1234));
        tick();
        chk("lat_cs_n2", 64'(mem_cs), 64'(0));
        chk("lat_rsp_n2", 64'(rsp_valid), 64'(0));
        tick();
        chk("lat_rsp_n3", 64'(rsp_valid), 64'(1));
        chk("lat_rdata_n3", 64'(rsp_rdata), 64'(32'hA500_0034));
        tick();
        chk("hold_rsp", 64'(rsp_valid), 64'(1));
        chk("hold_rdata", 64'(rsp_rdata), 64'(32'hA500_0034));
        rsp_ready = 1'b1;
        tick();
        chk("rsp_drop", 64'(rsp_valid), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));

        // Write then read back addresses 0x0..0xF
        snap = rsp_total;
        for (int i = 0; i < 16; i++) begin
            d = 32'h1357_0000 + 32'(i) * 32'h0001_1111;
            push(1'b1, 16'(i), d);
            push(1'b0, 16'(i), '0);
            get_rsp("wr_rd", d);
        end
        chk("wr_rd_rsp_count", 64'(rsp_total - snap), 64'(16));

        // Five reads with rsp_ready low: one in RESP, queue full
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(1'b0, 16'h0020 + 16'(i), '0);
        chk("full_ready", 64'(req_ready), 64'(0));
        chk("full_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("full_rdata", 64'(rsp_rdata), 64'(32'hA500_0020));
        chk("full_busy", 64'(busy), 64'(1));
        for (int i = 0; i < 5; i++) get_rsp("full_order", 32'hA500_0020 + 32'(i));
        chk("drain_busy", 64'(busy), 64'(0));

        // Reset while in RWAIT with two requests queued
        rsp_ready = 1'b1;
        push(1'b0, 16'h0030, '0);
        push(1'b0, 16'h0031, '0);
        push(1'b0, 16'h0032, '0);
        chk("rwait_busy", 64'(busy), 64'(1));
        chk("rwait_cs", 64'(mem_cs), 64'(0));
        reset = 1'b1;
        #1;
        chk("arst_req_ready", 64'(req_ready), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_strobes", 64'({mem_cs, mem_we, mem_re}), 64'(0));
        chk("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("arst_mem_addr", 64'(mem_addr), 64'(0));
        chk("arst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("arst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        snap = rsp_total;
        repeat (12) tick();
        chk("arst_no_rsp", 64'(rsp_total - snap), 64'(0));
        chk("arst_busy_after", 64'(busy), 64'(0));
        chk("arst_ready_after", 64'(req_ready), 64'(1));

        // Back-to-back writes
        snap = we_total;
        for (int i = 0; i < 3; i++) push(1'b1, 16'h0040 + 16'(i), 32'hC0DE_0040 + 32'(i));
        repeat (12) tick();
        chk("b2b_we_count", 64'(we_total - snap), 64'(3));
        chk("b2b_we_adjacent", 64'(adj_total), 64'(0));
        chk("b2b_we_re_overlap", 64'(overlap_total), 64'(0));
        push(1'b0, 16'h0041, '0);
        get_rsp("b2b_readback", 32'hC0DE_0041);

`ifdef MEM_REQ_CTRL_VERIFY_EN
        // Write-verify against a memory that reads back zero
        chk("verify_clean", 64'(verify_err), 64'(0));
        zero_rd = 1'b1;
        push(1'b1, 16'h0050, 32'hDEAD_BEEF);
        repeat (8) tick();
        chk("verify_set", 64'(verify_err), 64'(1));
        zero_rd = 1'b0;
        push(1'b0, 16'h0050, '0);
        get_rsp("verify_readback", 32'hDEAD_BEEF);
        repeat (5) tick();
        chk("verify_sticky", 64'(verify_err), 64'(1));
        reset = 1'b1;
        #1;
        chk("verify_cleared", 64'(verify_err), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        tick();
`else
        // Verify disabled: flag stays low even when memory reads back zero
        zero_rd = 1'b1;
        push(1'b1, 16'h0050, 32'hDEAD_BEEF);
        repeat (8) tick();
        chk("verify_tied_low", 64'(verify_err), 64'(0));
        zero_rd = 1'b0;
`endif

        chk("final_overlap", 64'(overlap_total), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, memory data width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, request queue entries (power of 2, minimum 2).
REQ-004 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1, request present.
REQ-007 The block SHALL have port req_ready, output, 1, queue can accept.
REQ-008 The block SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, ADDR_WIDTH, request address.
REQ-010 The block SHALL have port req_wdata, input, DATA_WIDTH, write data.
REQ-011 The block SHALL have port rsp_valid, output, 1, read data available.
REQ-012 The block SHALL have port rsp_ready, input, 1, consumer accepts response.
REQ-013 The block SHALL have port rsp_rdata, output, DATA_WIDTH, read data.
REQ-014 The block SHALL have ports mem_addr (output, ADDR_WIDTH), mem_cs, mem_we and mem_re (each output, 1), mem_wdata (output, DATA_WIDTH), and mem_rdata (input, DATA_WIDTH), the downstream memory port.
REQ-015 The block SHALL have port busy, output, 1, high when the FSM is not IDLE or the queue is non-empty.
REQ-016 The block SHALL have port verify_err, output, 1, sticky write-verify mismatch flag.

Function
REQ-017 Request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1, and stored in a FIFO of FIFO_DEPTH entries.
REQ-018 req_ready SHALL equal not-full, registered; a push while full is impossible; simultaneous push and pop SHALL keep the count unchanged.
REQ-019 The FSM SHALL have states IDLE, WR, RD, RWAIT, RESP, plus VRD and VWAIT when verify is compiled in.
REQ-020 IDLE with a non-empty FIFO SHALL pop the head and go to WR (write) or RD (read); otherwise it SHALL stay in IDLE.
REQ-021 In WR the block SHALL drive mem_cs=1, mem_we=1, mem_re=0, and the popped address and data for exactly one cycle, then go to IDLE.
REQ-022 In RD the block SHALL drive mem_cs=1, mem_re=1, mem_we=0, and the popped address for one cycle, then go to RWAIT.
REQ-023 In RWAIT the block SHALL sample mem_rdata into rsp_rdata (the memory read latency is 1 cycle) and go to RESP.
REQ-024 In RESP, rsp_valid SHALL be 1 with rsp_rdata stable until rsp_ready=1, then the FSM goes to IDLE; writes SHALL produce no response.
REQ-025 Outside WR/RD/VRD, mem_cs, mem_we and mem_re SHALL be 0; mem_we and mem_re SHALL never be high together.
REQ-026 Latency: for a request accepted at edge N into an empty, idle block, the memory strobe SHALL be high during the cycle between edges N+1 and N+2.
REQ-027 Read-to-response latency SHALL be rsp_valid high from edge N+3; requests SHALL be serviced strictly in acceptance order.
REQ-028 Address and data SHALL pass unmodified; no wrap or arithmetic is applied to requests; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 On reset assertion the block SHALL, immediately and asynchronously, empty the FIFO, set the FSM to IDLE, and drive req_ready=0 and all other outputs to 0.
REQ-030 req_ready SHALL rise on the first clock edge after reset deasserts.
REQ-031 Reset during an in-flight read SHALL drop the response; queued requests SHALL be discarded.

Configuration
REQ-032 With macro MEM_REQ_CTRL_VERIFY_EN defined, WR SHALL go to VRD, which reads the same address for one cycle, and then to VWAIT.
REQ-033 In VWAIT the block SHALL compare mem_rdata with the written data; a mismatch SHALL set verify_err sticky until reset; VWAIT then goes to IDLE with no response.
REQ-034 Without MEM_REQ_CTRL_VERIFY_EN, the states VRD and VWAIT SHALL be absent, WR SHALL go to IDLE, and verify_err SHALL be tied to 0.

Verification
REQ-035 Write addresses 0x0000..0x000F with random data, each followed by a read of the same address -> each rsp_rdata equals the written data, with no response for writes.
REQ-036 Push 5 reads with rsp_ready=0 and FIFO_DEPTH=4 -> one read is in RESP, req_ready=0 after the queue fills, and no request is lost after rsp_ready is raised.
REQ-037 Single read at address 0x1234 accepted at edge N -> mem_cs=mem_re=1 only in cycle N+1..N+2, and rsp_valid at N+3.
REQ-038 Assert reset while in RWAIT with 2 queued requests -> all outputs 0 immediately, no rsp_valid afterwards, and busy=0.
REQ-039 With MEM_REQ_CTRL_VERIFY_EN defined, write 0xDEADBEEF while the memory model returns 0x00000000 -> verify_err=1 and stays 1 until reset.
REQ-040 Back-to-back writes -> never mem_we and mem_re high together, and one IDLE cycle between strobes.
